// File: rtl/ram_cmd_arbiter_if.sv
// Bundle of requester handshakes, read responses and the RAM command/data link
// shared by the arbiter (slave side) and its environment (master side).
interface ram_cmd_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8
) ();
  logic                 req0_valid;
  logic                 req0_ready;
  logic                 req0_wr;
  logic [ADDR_SIZE-1:0] req0_addr;
  logic [7:0]           req0_wdata;

  logic                 req1_valid;
  logic                 req1_ready;
  logic                 req1_wr;
  logic [ADDR_SIZE-1:0] req1_addr;
  logic [7:0]           req1_wdata;

  logic                 rsp0_valid;
  logic [7:0]           rsp0_data;
  logic                 rsp1_valid;
  logic [7:0]           rsp1_data;

  logic [9:0]           ram_din;
  logic                 ram_rx_valid;
  logic [7:0]           ram_dout;
  logic                 ram_tx_valid;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output ram_din, ram_rx_valid,
    input  ram_dout, ram_tx_valid
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  ram_din, ram_rx_valid,
    output ram_dout, ram_tx_valid
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter serialising two requesters' word reads/writes into the RAM's
// 10-bit command stream, with optional elision of redundant address commands.
module ram_cmd_arbiter #(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned TIMEOUT    = 8,
  parameter bit          ADDR_ELIDE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  ram_cmd_arbiter_if.slave bus,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StWaitTx} state_e;

  state_e               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 id_q, id_d;
  logic                 last_grant_q, last_grant_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [ADDR_SIZE-1:0] wr_shadow_q, wr_shadow_d;
  logic [ADDR_SIZE-1:0] rd_shadow_q, rd_shadow_d;
  logic                 wr_shadow_vld_q, wr_shadow_vld_d;
  logic                 rd_shadow_vld_q, rd_shadow_vld_d;

  logic [9:0]           din_q, din_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rsp0_valid_q, rsp0_valid_d;
  logic                 rsp1_valid_q, rsp1_valid_d;
  logic [7:0]           rsp0_data_q, rsp0_data_d;
  logic [7:0]           rsp1_data_q, rsp1_data_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 accept;
  logic                 grant;
  logic                 sel_wr;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 elide;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    accept = 1'b0;
    grant  = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        accept = 1'b1;
        grant  = ~last_grant_q;
      end else if (bus.req0_valid) begin
        accept = 1'b1;
        grant  = 1'b0;
      end else if (bus.req1_valid) begin
        accept = 1'b1;
        grant  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign sel_wr    = grant ? bus.req1_wr    : bus.req0_wr;
  assign sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;

  always_comb begin
    elide = 1'b0;
    if (ADDR_ELIDE) begin
      if (sel_wr) begin
        elide = wr_shadow_vld_q && (wr_shadow_q == sel_addr);
      end else begin
        elide = rd_shadow_vld_q && (rd_shadow_q == sel_addr);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_d            = wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    id_d            = id_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    wr_shadow_d     = wr_shadow_q;
    rd_shadow_d     = rd_shadow_q;
    wr_shadow_vld_d = wr_shadow_vld_q;
    rd_shadow_vld_d = rd_shadow_vld_q;
    rsp0_valid_d    = 1'b0;
    rsp1_valid_d    = 1'b0;
    rsp0_data_d     = rsp0_data_q;
    rsp1_data_d     = rsp1_data_q;
    timeout_err_d   = timeout_err_q;
    rx_valid_d      = 1'b0;
    din_d           = 10'h000;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_d         = sel_wr;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = elide ? StData : StAddr;
        end
      end
      StAddr: begin
        if (wr_q) begin
          wr_shadow_d     = addr_q;
          wr_shadow_vld_d = 1'b1;
        end else begin
          rd_shadow_d     = addr_q;
          rd_shadow_vld_d = 1'b1;
        end
        state_d = StData;
      end
      StData: begin
        if (wr_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = 8'd0;
          state_d = StWaitTx;
        end
      end
      StWaitTx: begin
        if (bus.ram_tx_valid || cnt_q == 8'(TIMEOUT - 1)) begin
          if (!bus.ram_tx_valid) begin
            timeout_err_d = 1'b1;
          end
          if (id_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = bus.ram_tx_valid ? bus.ram_dout : 8'h00;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = bus.ram_tx_valid ? bus.ram_dout : 8'h00;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    // Command outputs are registered and take the value of the state being entered.
    unique case (state_d)
      StAddr: begin
        rx_valid_d = 1'b1;
        din_d      = {(wr_d ? 2'b00 : 2'b10), addr_d};
      end
      StData: begin
        rx_valid_d = 1'b1;
        din_d      = wr_d ? {2'b01, wdata_d} : {2'b11, 8'h00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= 8'h00;
      id_q            <= 1'b0;
      last_grant_q    <= 1'b1;
      cnt_q           <= 8'd0;
      wr_shadow_q     <= '0;
      rd_shadow_q     <= '0;
      wr_shadow_vld_q <= 1'b0;
      rd_shadow_vld_q <= 1'b0;
      din_q           <= 10'h000;
      rx_valid_q      <= 1'b0;
      rsp0_valid_q    <= 1'b0;
      rsp1_valid_q    <= 1'b0;
      rsp0_data_q     <= 8'h00;
      rsp1_data_q     <= 8'h00;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      id_q            <= id_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      wr_shadow_q     <= wr_shadow_d;
      rd_shadow_q     <= rd_shadow_d;
      wr_shadow_vld_q <= wr_shadow_vld_d;
      rd_shadow_vld_q <= rd_shadow_vld_d;
      din_q           <= din_d;
      rx_valid_q      <= rx_valid_d;
      rsp0_valid_q    <= rsp0_valid_d;
      rsp1_valid_q    <= rsp1_valid_d;
      rsp0_data_q     <= rsp0_data_d;
      rsp1_data_q     <= rsp1_data_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rx_valid_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp0_data    = rsp0_data_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp1_data    = rsp1_data_q;
  assign busy             = (state_q != StIdle);
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a small behavioural model of the RAM.
module tb_ram_cmd_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;
  int   total = 0;
  int   bad   = 0;

  ram_cmd_arbiter_if #(.ADDR_SIZE(8)) bus ();

  ram_cmd_arbiter #(
    .ADDR_SIZE (8),
    .TIMEOUT   (8),
    .ADDR_ELIDE(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RAM model: separate write/read address registers, read data valid is a level
  // that any non-read command clears. tx_block suppresses read data entirely.
  logic [7:0] mem [256];
  logic [7:0] ram_wa   = 8'h00;
  logic [7:0] ram_ra   = 8'h00;
  logic [7:0] dout     = 8'h00;
  logic       tx_v     = 1'b0;
  logic       tx_block = 1'b0;

  assign bus.ram_dout     = dout;
  assign bus.ram_tx_valid = tx_v;

  always @(posedge clk) begin
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00: begin ram_wa <= bus.ram_din[7:0]; tx_v <= 1'b0; end
        2'b01: begin mem[ram_wa] <= bus.ram_din[7:0]; tx_v <= 1'b0; end
        2'b10: begin ram_ra <= bus.ram_din[7:0]; tx_v <= 1'b0; end
        default: begin dout <= mem[ram_ra]; tx_v <= !tx_block; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    nxt();
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", bus.ram_rx_valid, 0);
    chk("rst_din", bus.ram_din, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp0", bus.rsp0_valid, 0);
    chk("rst_rsp1", bus.rsp1_valid, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;

    // Full write from requester 0.
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'h12; bus.req0_wdata = 8'hA5;
    #1;
    chk("w_ready0", bus.req0_ready, 1);
    chk("w_ready1", bus.req1_ready, 0);
    nxt(); bus.req0_valid = 1'b0;
    chk("w_c1_rx", bus.ram_rx_valid, 1);
    chk("w_c1_din", bus.ram_din, 10'h012);
    chk("w_c1_busy", busy, 1);
    nxt();
    chk("w_c2_din", bus.ram_din, 10'h1A5);
    nxt();
    chk("w_c3_rx", bus.ram_rx_valid, 0);
    chk("w_c3_busy", busy, 0);
    bus.req0_valid = 1'b1;
    #1;
    chk("w_c3_ready0", bus.req0_ready, 1);
    bus.req0_valid = 1'b0;

    // Read of the same address by requester 1.
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b0; bus.req1_addr = 8'h12;
    #1;
    chk("r_ready1", bus.req1_ready, 1);
    chk("r_ready0", bus.req0_ready, 0);
    nxt(); bus.req1_valid = 1'b0;
    chk("r_c1_din", bus.ram_din, 10'h212);
    nxt();
    chk("r_c2_din", bus.ram_din, 10'h300);
    nxt();
    chk("r_c3_busy", busy, 1);
    chk("r_c3_rx", bus.ram_rx_valid, 0);
    chk("r_c3_rsp1", bus.rsp1_valid, 0);
    nxt();
    chk("r_c4_rsp1", bus.rsp1_valid, 1);
    chk("r_c4_data1", bus.rsp1_data, 8'hA5);
    chk("r_c4_rsp0", bus.rsp0_valid, 0);
    chk("r_c4_busy", busy, 0);
    nxt();
    chk("r_c5_rsp1", bus.rsp1_valid, 0);

    // Both requesters held valid: grants must alternate 0,1,0,1.
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'h01; bus.req0_wdata = 8'h10;
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b1; bus.req1_addr = 8'h02; bus.req1_wdata = 8'h20;
    for (int i = 0; i < 4; i++) begin
      logic even;
      even = (i % 2 == 0);
      #1;
      chk("rr_ready0", bus.req0_ready, even);
      chk("rr_ready1", bus.req1_ready, !even);
      nxt();
      chk("rr_addr_cmd", bus.ram_din, even ? 10'h001 : 10'h002);
      nxt();
      chk("rr_data_cmd", bus.ram_din, even ? 10'h110 : 10'h120);
      nxt();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Back-to-back writes to one address: the second skips its address command.
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'h40; bus.req0_wdata = 8'h11;
    nxt();
    chk("el_c1_din", bus.ram_din, 10'h040);
    bus.req0_wdata = 8'h22;
    nxt();
    chk("el_c2_din", bus.ram_din, 10'h111);
    nxt();
    #1;
    chk("el_c3_ready0", bus.req0_ready, 1);
    nxt();
    bus.req0_valid = 1'b0;
    chk("el_c4_din", bus.ram_din, 10'h122);
    chk("el_c4_rx", bus.ram_rx_valid, 1);
    nxt();
    chk("el_c5_rx", bus.ram_rx_valid, 0);
    chk("el_c5_busy", busy, 0);

    // Reset invalidates the shadows, so the address is issued again.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b1; bus.req0_addr = 8'h40; bus.req0_wdata = 8'h33;
    nxt(); bus.req0_valid = 1'b0;
    chk("el_rst_din", bus.ram_din, 10'h040);
    nxt();
    chk("el_rst_data", bus.ram_din, 10'h133);
    nxt();

    // Full read, then an elided read of the same address.
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b0; bus.req0_addr = 8'h40;
    nxt(); bus.req0_valid = 1'b0;
    chk("rd_c1_din", bus.ram_din, 10'h240);
    nxt();
    chk("rd_c2_din", bus.ram_din, 10'h300);
    nxt();
    nxt();
    chk("rd_c4_rsp0", bus.rsp0_valid, 1);
    chk("rd_c4_data0", bus.rsp0_data, 8'h33);
    bus.req0_valid = 1'b1;
    #1;
    chk("rd_c4_ready0", bus.req0_ready, 1);
    nxt(); bus.req0_valid = 1'b0;
    chk("erd_c1_din", bus.ram_din, 10'h300);
    nxt();
    chk("erd_c2_busy", busy, 1);
    chk("erd_c2_rsp0", bus.rsp0_valid, 0);
    nxt();
    chk("erd_c3_rsp0", bus.rsp0_valid, 1);
    chk("erd_c3_data0", bus.rsp0_data, 8'h33);

    // Read with no returned data: abandoned after eight WAIT_TX cycles.
    tx_block = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_wr = 1'b0; bus.req1_addr = 8'h12;
    nxt(); bus.req1_valid = 1'b0;
    chk("to_c1_din", bus.ram_din, 10'h212);
    nxt();
    chk("to_c2_din", bus.ram_din, 10'h300);
    repeat (7) nxt();
    nxt();
    chk("to_c10_busy", busy, 1);
    chk("to_c10_rsp1", bus.rsp1_valid, 0);
    chk("to_c10_terr", timeout_err, 0);
    nxt();
    chk("to_c11_rsp1", bus.rsp1_valid, 1);
    chk("to_c11_data1", bus.rsp1_data, 8'h00);
    chk("to_c11_terr", timeout_err, 1);
    chk("to_c11_busy", busy, 0);
    nxt();
    chk("to_c12_rsp1", bus.rsp1_valid, 0);
    chk("to_c12_terr", timeout_err, 1);

    // Reset while waiting for read data abandons the read and clears the sticky error.
    bus.req0_valid = 1'b1; bus.req0_wr = 1'b0; bus.req0_addr = 8'h55;
    nxt(); bus.req0_valid = 1'b0;
    chk("rw_c1_din", bus.ram_din, 10'h255);
    nxt();
    nxt();
    chk("rw_c3_busy", busy, 1);
    chk("rw_c3_terr", timeout_err, 1);
    rst = 1'b1;
    nxt();
    chk("rw_busy", busy, 0);
    chk("rw_rsp0", bus.rsp0_valid, 0);
    chk("rw_terr", timeout_err, 0);
    chk("rw_rx", bus.ram_rx_valid, 0);
    chk("rw_data0", bus.rsp0_data, 8'h00);
    rst = 1'b0;
    nxt();
    chk("rw_after_rsp0", bus.rsp0_valid, 0);
    chk("rw_after_rx", bus.ram_rx_valid, 0);
    chk("rw_after_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
